// File: rtl/pipe_hazard_ctrl_if.sv
// Instruction/data bus request and completion strobes seen by the hazard controller.
// The bus side drives every strobe; the controller only observes them.
interface pipe_hazard_ctrl_if;
  logic i_start;
  logic i_done;
  logic d_start;
  logic d_done;

  modport master (output i_start, output i_done, output d_start, output d_done);
  modport slave  (input  i_start, input  i_done, input  d_start, input  d_done);
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline sequencer: stage enables, squash controls, E-stage forwarding selects.
// Optional macro PIPE_STALL_CNT_EN adds a free-running 32-bit stall-cycle counter output.
module pipe_hazard_ctrl #(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  pipe_hazard_ctrl_if.slave bus,
  input  logic [REG_W-1:0] d_rs,
  input  logic [REG_W-1:0] d_rt,
  input  logic [REG_W-1:0] e_rs,
  input  logic [REG_W-1:0] e_rt,
  input  logic [REG_W-1:0] e_rd,
  input  logic             e_mem_to_reg,
  input  logic             e_reg_write,
  input  logic             e_branch_taken,
  input  logic [REG_W-1:0] m_rd,
  input  logic             m_reg_write,
  input  logic [REG_W-1:0] w_rd,
  input  logic             w_reg_write,
  output logic [5:0]       en,
  output logic             flush_d,
  output logic             flush_e,
  output logic             fetch_drop,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       bus_state
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  typedef logic [REG_W-1:0] creg_addr_t;

  typedef struct packed {
    logic fetch;
    logic decode;
    logic execute;
    logic memory;
    logic writeback;
    logic m_or_e;
  } state_enable_t;

  // Bit 0 = instruction fetch outstanding, bit 1 = data access outstanding.
  typedef enum logic [1:0] {
    RUN     = 2'b00,
    WAIT_I  = 2'b01,
    WAIT_D  = 2'b10,
    WAIT_ID = 2'b11
  } bus_state_t;

  bus_state_t    state, state_nxt;
  logic          i_pend, d_pend, i_pend_nxt, d_pend_nxt;
  logic          pend_any, d_wait, load_use;
  logic          drop_pend, drop_pend_nxt;
  state_enable_t en_s;

  function automatic logic [1:0] fwd_sel(input creg_addr_t src);
    if (m_reg_write && (m_rd != '0) && (m_rd == src))      fwd_sel = 2'b10;
    else if (w_reg_write && (w_rd != '0) && (w_rd == src)) fwd_sel = 2'b01;
    else                                                   fwd_sel = 2'b00;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      drop_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      drop_pend <= drop_pend_nxt;
    end
  end

  // A start with a same-cycle done never becomes pending; a stray done is a no-op.
  always_comb begin
    i_pend     = state[0];
    d_pend     = state[1];
    i_pend_nxt = (i_pend | bus.i_start) & ~bus.i_done;
    d_pend_nxt = (d_pend | bus.d_start) & ~bus.d_done;
    state_nxt  = bus_state_t'({d_pend_nxt, i_pend_nxt});
    pend_any   = (state != RUN) || (state_nxt != RUN);
    d_wait     = d_pend | d_pend_nxt;
  end

  // The fetch in flight belongs to the old PC once E redirects; drop it when it returns.
  always_comb begin
    drop_pend_nxt = drop_pend;
    if (bus.i_done)                     drop_pend_nxt = 1'b0;
    else if (i_pend && e_branch_taken)  drop_pend_nxt = 1'b1;
  end

  assign load_use = e_mem_to_reg && e_reg_write && (e_rd != '0) &&
                    ((e_rd == d_rs) || (e_rd == d_rt));

  always_comb begin
    en_s       = '0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    fwd_a      = 2'b00;
    fwd_b      = 2'b00;
    fetch_drop = 1'b0;
    if (reset) begin
      fwd_a      = fwd_sel(e_rs);
      fwd_b      = fwd_sel(e_rt);
      fetch_drop = drop_pend & bus.i_done;
      if (pend_any) begin
        en_s.m_or_e = d_wait;
      end else if (e_branch_taken) begin
        en_s    = '{fetch: 1'b1, decode: 1'b1, execute: 1'b1, memory: 1'b1,
                    writeback: 1'b1, m_or_e: 1'b0};
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (load_use) begin
        en_s    = '{fetch: 1'b0, decode: 1'b0, execute: 1'b1, memory: 1'b1,
                    writeback: 1'b1, m_or_e: 1'b0};
        flush_e = 1'b1;
      end else begin
        en_s    = '{fetch: 1'b1, decode: 1'b1, execute: 1'b1, memory: 1'b1,
                    writeback: 1'b1, m_or_e: 1'b0};
      end
    end
  end

  assign en        = en_s;
  assign bus_state = state;

`ifdef PIPE_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cycles <= '0;
    else if (!(en_s.fetch && en_s.decode && en_s.execute))
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hand-derived expected output vectors queued per step.
module tb_pipe_hazard_ctrl;
  logic       clk;
  logic       reset;
  logic [4:0] d_rs, d_rt, e_rs, e_rt, e_rd, m_rd, w_rd;
  logic       e_mem_to_reg, e_reg_write, e_branch_taken, m_reg_write, w_reg_write;
  logic [5:0] en;
  logic       flush_d, flush_e, fetch_drop;
  logic [1:0] fwd_a, fwd_b, bus_state;
`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int errors = 0;
  int checks = 0;
  logic [14:0] exp_q[$];
  string       tag_q[$];

  localparam logic [1:0] S_RUN = 2'd0, S_WI = 2'd1, S_WD = 2'd2, S_WID = 2'd3;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.REG_W(5)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .d_rs(d_rs), .d_rt(d_rt), .e_rs(e_rs), .e_rt(e_rt), .e_rd(e_rd),
    .e_mem_to_reg(e_mem_to_reg), .e_reg_write(e_reg_write),
    .e_branch_taken(e_branch_taken), .m_rd(m_rd), .m_reg_write(m_reg_write),
    .w_rd(w_rd), .w_reg_write(w_reg_write), .en(en), .flush_d(flush_d),
    .flush_e(flush_e), .fetch_drop(fetch_drop), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .bus_state(bus_state)
`ifdef PIPE_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] pk(input logic [5:0] e, input logic fd, input logic fe,
                                     input logic drop, input logic [1:0] fa,
                                     input logic [1:0] fb, input logic [1:0] st);
    pk = {e, fd, fe, drop, fa, fb, st};
  endfunction

  // driver tasks
  task automatic idle();
    bus.i_start = 0; bus.i_done = 0; bus.d_start = 0; bus.d_done = 0;
    d_rs = 5'd1; d_rt = 5'd2; e_rs = 5'd0; e_rt = 5'd0; e_rd = 5'd0;
    e_mem_to_reg = 0; e_reg_write = 0; e_branch_taken = 0;
    m_rd = 5'd0; m_reg_write = 0; w_rd = 5'd0; w_reg_write = 0;
  endtask

  task automatic expect_out(input string tag, input logic [14:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  // scoreboard
  task automatic check_out();
    logic [14:0] obs, exp;
    string tag;
    obs = {en, flush_d, flush_e, fetch_drop, fwd_a, fwd_b, bus_state};
    exp = exp_q.pop_front();
    tag = tag_q.pop_front();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (en,fd,fe,drop,fa,fb,state)", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [14:0] exp);
    expect_out(tag, exp);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    bus.d_start = 1; m_rd = 5'd5; m_reg_write = 1; e_rs = 5'd5;
    #3;
    step("rst_hold", pk(6'b000000, 0, 0, 0, 2'b00, 2'b00, S_RUN));
    reset = 1'b1;
    idle();
    step("idle", pk(6'b111110, 0, 0, 0, 2'b00, 2'b00, S_RUN));
`ifdef PIPE_STALL_CNT_EN
    checks++;
    assert (stall_cycles === 32'd0) else begin
      errors++; $error("FAIL stall_init observed=%0d expected=0", stall_cycles);
    end
`endif

    // forwarding
    idle(); m_rd = 5'd5; w_rd = 5'd5; e_rs = 5'd5; m_reg_write = 1; w_reg_write = 1;
    step("fwd_m_over_w", pk(6'b111110, 0, 0, 0, 2'b10, 2'b00, S_RUN));
    idle(); m_rd = 5'd0; w_rd = 5'd5; e_rs = 5'd5; m_reg_write = 1; w_reg_write = 1;
    step("fwd_w", pk(6'b111110, 0, 0, 0, 2'b01, 2'b00, S_RUN));
    idle(); m_rd = 5'd5; w_rd = 5'd5; e_rs = 5'd0; e_rt = 5'd5; m_reg_write = 1; w_reg_write = 1;
    step("fwd_r0_and_b", pk(6'b111110, 0, 0, 0, 2'b00, 2'b10, S_RUN));
    idle(); m_rd = 5'd7; w_rd = 5'd7; e_rt = 5'd7; m_reg_write = 0; w_reg_write = 1;
    step("fwd_b_w_only", pk(6'b111110, 0, 0, 0, 2'b00, 2'b01, S_RUN));

    // load-use then forward from M
    idle(); e_mem_to_reg = 1; e_reg_write = 1; e_rd = 5'd8; d_rt = 5'd8;
    step("load_use", pk(6'b001110, 0, 1, 0, 2'b00, 2'b00, S_RUN));
    idle(); m_rd = 5'd8; m_reg_write = 1; e_rt = 5'd8;
    step("load_fwd", pk(6'b111110, 0, 0, 0, 2'b00, 2'b10, S_RUN));
    idle(); e_mem_to_reg = 1; e_reg_write = 1; e_rd = 5'd0; d_rs = 5'd0;
    step("load_r0", pk(6'b111110, 0, 0, 0, 2'b00, 2'b00, S_RUN));
    idle(); e_mem_to_reg = 1; e_reg_write = 1; e_rd = 5'd8; d_rs = 5'd8; e_branch_taken = 1;
    step("branch_load", pk(6'b111110, 1, 1, 0, 2'b00, 2'b00, S_RUN));

    // data bus wait
    idle(); bus.d_start = 1;
    step("dwait_c0", pk(6'b000001, 0, 0, 0, 2'b00, 2'b00, S_RUN));
    for (int i = 1; i <= 3; i++) begin
      idle();
      step($sformatf("dwait_c%0d", i), pk(6'b000001, 0, 0, 0, 2'b00, 2'b00, S_WD));
    end
    idle(); bus.d_done = 1;
    step("dwait_done", pk(6'b000001, 0, 0, 0, 2'b00, 2'b00, S_WD));
    idle();
    step("dwait_resume", pk(6'b111110, 0, 0, 0, 2'b00, 2'b00, S_RUN));
    idle(); bus.d_start = 1; bus.d_done = 1;
    step("d_same_cycle", pk(6'b111110, 0, 0, 0, 2'b00, 2'b00, S_RUN));
    idle(); bus.i_done = 1;
    step("stray_i_done", pk(6'b111110, 0, 0, 0, 2'b00, 2'b00, S_RUN));

    // redirect while fetch pending
    idle(); bus.i_start = 1;
    step("ifetch_start", pk(6'b000000, 0, 0, 0, 2'b00, 2'b00, S_RUN));
    idle(); e_branch_taken = 1;
    step("redirect_wait", pk(6'b000000, 0, 0, 0, 2'b00, 2'b00, S_WI));
    idle();
    step("wait_i_hold", pk(6'b000000, 0, 0, 0, 2'b00, 2'b00, S_WI));
    idle(); bus.i_done = 1;
    step("fetch_drop", pk(6'b000000, 0, 0, 1, 2'b00, 2'b00, S_WI));
    idle();
    step("drop_cleared", pk(6'b111110, 0, 0, 0, 2'b00, 2'b00, S_RUN));
    idle(); bus.i_start = 1; bus.i_done = 1;
    step("no_second_drop", pk(6'b111110, 0, 0, 0, 2'b00, 2'b00, S_RUN));

    // async reset in WAIT_ID
    idle(); bus.i_start = 1; bus.d_start = 1;
    step("wid_start", pk(6'b000001, 0, 0, 0, 2'b00, 2'b00, S_RUN));
    idle(); m_rd = 5'd5; m_reg_write = 1; e_rs = 5'd5;
    expect_out("wid_hold", pk(6'b000001, 0, 0, 0, 2'b10, 2'b00, S_WID));
    @(negedge clk);
    check_out();
    #1 reset = 1'b0;
    expect_out("async_rst", pk(6'b000000, 0, 0, 0, 2'b00, 2'b00, S_RUN));
    #1 check_out();
    @(posedge clk);
    #1 reset = 1'b1;
    idle();
    step("post_rst", pk(6'b111110, 0, 0, 0, 2'b00, 2'b00, S_RUN));
`ifdef PIPE_STALL_CNT_EN
    checks++;
    assert (stall_cycles === 32'd0) else begin
      errors++; $error("FAIL stall_post_rst observed=%0d expected=0", stall_cycles);
    end
`endif

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++; $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
    end

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
